mod_exp_ctrl: RTL and testbench

- Sequencer that computes y = base^exp mod m by left-to-right square-and-multiply.
- Drives one external interleaved modular multiplier (enable_p/done_irq_p handshake, NBITS operands) and holds the running accumulator.
- Sits between the host/register layer and a single mod_mul engine instance; the engine is not instantiated inside this block.

---
 rtl/mod_exp_ctrl_if.sv | 21 ++
 rtl/mod_exp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_ctrl_if.sv
// Bus between the exponentiation sequencer and one modular-multiplier engine.
interface mod_exp_ctrl_if #(
  parameter int unsigned NBITS = 4096
);
  logic             mul_enable_p;
  logic [NBITS-1:0] mul_a;
  logic [NBITS-1:0] mul_b;
  logic [NBITS-1:0] mul_m;
  logic [NBITS-1:0] mul_y;
  logic             mul_done_irq_p;

  modport master (
    output mul_enable_p, mul_a, mul_b, mul_m,
    input  mul_y, mul_done_irq_p
  );

  modport slave (
    input  mul_enable_p, mul_a, mul_b, mul_m,
    output mul_y, mul_done_irq_p
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod m
// through an external modular multiplier on the mod_exp_ctrl_if bus.
module mod_exp_ctrl #(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned EBITS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             done_irq_p,
  mod_exp_ctrl_if.master   mul
);

  // idx carries one extra MSB that becomes set when it decrements past zero
  localparam int unsigned IW = $clog2(EBITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SQR_GO, S_SQR_WAIT, S_MUL_GO, S_MUL_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] base_loc_q, base_loc_d;
  logic [EBITS-1:0] exp_loc_q, exp_loc_d;
  logic [NBITS-1:0] m_loc_q, m_loc_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             seen_one_q, seen_one_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [NBITS-1:0] mul_a_q, mul_a_d;
  logic [NBITS-1:0] mul_b_q, mul_b_d;

  logic idx_uf;
  logic exp_bit;
  logic last_zero;

  assign idx_uf    = idx_q[IW-1];
  assign exp_bit   = exp_loc_q[idx_q[IW-2:0]];
  // no set bit yet and the lowest bit is zero: exponent is 0, finish directly
  assign last_zero = !seen_one_q && !exp_bit && (idx_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_p) state_d = S_SCAN;
      S_SCAN: begin
        if (idx_uf || last_zero) state_d = S_DONE;
        else if (seen_one_q)     state_d = S_SQR_GO;
        else                     state_d = S_SCAN;
      end
      S_SQR_GO:   state_d = S_SQR_WAIT;
      S_SQR_WAIT: if (mul.mul_done_irq_p) state_d = exp_bit ? S_MUL_GO : S_SCAN;
      S_MUL_GO:   state_d = S_MUL_WAIT;
      S_MUL_WAIT: if (mul.mul_done_irq_p) state_d = S_SCAN;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath
  always_comb begin
    busy             = (state_q != S_IDLE);
    done_irq_p       = (state_q == S_DONE);
    mul.mul_enable_p = (state_q == S_SQR_GO) || (state_q == S_MUL_GO);
    mul.mul_a        = mul_a_q;
    mul.mul_b        = mul_b_q;
    mul.mul_m        = m_loc_q;
    result           = result_q;
  end

  // Datapath next values; operands are loaded one cycle ahead of each GO state
  // so they are already stable in the mul_enable_p cycle.
  always_comb begin
    base_loc_d = base_loc_q;
    exp_loc_d  = exp_loc_q;
    m_loc_d    = m_loc_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    seen_one_d = seen_one_q;
    result_d   = result_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          base_loc_d = base;
          exp_loc_d  = exp;
          m_loc_d    = m;
          idx_d      = IW'(EBITS - 1);
          seen_one_d = 1'b0;
        end
      end
      S_SCAN: begin
        // result is loaded on entry to DONE so it is valid with done_irq_p
        if (idx_uf || last_zero) begin
          result_d = seen_one_q ? acc_q : NBITS'(1);
        end else if (seen_one_q) begin
          mul_a_d = acc_q;
          mul_b_d = acc_q;
        end else begin
          if (exp_bit) begin
            acc_d      = base_loc_q;
            seen_one_d = 1'b1;
          end
          idx_d = idx_q - IW'(1);
        end
      end
      S_SQR_WAIT: begin
        if (mul.mul_done_irq_p) begin
          acc_d = mul.mul_y;
          if (exp_bit) begin
            mul_a_d = mul.mul_y;
            mul_b_d = base_loc_q;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      S_MUL_WAIT: begin
        if (mul.mul_done_irq_p) begin
          acc_d = mul.mul_y;
          idx_d = idx_q - IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_loc_q <= '0;
      exp_loc_q  <= '0;
      m_loc_q    <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      seen_one_q <= 1'b0;
      result_q   <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
    end else begin
      base_loc_q <= base_loc_d;
      exp_loc_q  <= exp_loc_d;
      m_loc_q    <= m_loc_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      seen_one_q <= seen_one_d;
      result_q   <= result_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with an 8-bit behavioural multiplier.
module tb_mod_exp_ctrl;
  localparam int unsigned NB = 8;
  localparam int unsigned EB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_p = 1'b0;
  logic [NB-1:0] base = '0;
  logic [EB-1:0] exp = '0;
  logic [NB-1:0] m = '0;
  logic [NB-1:0] result;
  logic          busy;
  logic          done_irq_p;

  mod_exp_ctrl_if #(.NBITS(NB)) mul_if ();

  mod_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .base(base), .exp(exp), .m(m),
    .result(result), .busy(busy), .done_irq_p(done_irq_p), .mul(mul_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // multiplier engine model: random latency, occasional stray done pulses
  logic          pend;
  int            dly;
  logic [NB-1:0] ca, cb, cm;
  int            mulcnt = 0;
  int            stab_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend                  <= 1'b0;
      dly                   <= 0;
      mul_if.mul_done_irq_p <= 1'b0;
      mul_if.mul_y          <= '0;
    end else begin
      mul_if.mul_done_irq_p <= 1'b0;
      if (pend) begin
        if (dly == 0) begin
          mul_if.mul_done_irq_p <= 1'b1;
          mul_if.mul_y          <= NB'((int'(ca) * int'(cb)) % int'(cm));
          pend                  <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end else if (mul_if.mul_enable_p) begin
        pend   <= 1'b1;
        dly    <= int'($urandom_range(0, 3));
        ca     <= mul_if.mul_a;
        cb     <= mul_if.mul_b;
        cm     <= mul_if.mul_m;
        mulcnt <= mulcnt + 1;
      end else if ($urandom_range(0, 7) == 0) begin
        mul_if.mul_done_irq_p <= 1'b1;
        mul_if.mul_y          <= NB'($urandom);
      end
    end
  end

  // operands must not move while a multiplication is outstanding
  always @(negedge clk) begin
    if (rst_n && pend &&
        (mul_if.mul_a != ca || mul_if.mul_b != cb || mul_if.mul_m != cm))
      stab_err++;
  end

  // reference: repeated multiplication, and multiplication count from bit statistics
  function automatic int ref_pow(input int b, input int e, input int md);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % md;
    return r;
  endfunction

  function automatic int ref_muls(input int e);
    int bl = 0;
    if (e == 0) return 0;
    for (int i = 0; i < 32; i++) if ((e >> i) != 0) bl = i + 1;
    return (bl - 1) + ($countones(e) - 1);
  endfunction

  typedef struct {
    int b; int e; int md;
    int res; int muls; int lat;
    bit intf; bit done_start;
  } vec_t;

  // called at #1 after a posedge with the DUT in IDLE
  task automatic run_case(input vec_t v, input string tag);
    int lat, m0, s0;
    m0 = mulcnt;
    s0 = stab_err;
    base = NB'(v.b); exp = EB'(v.e); m = NB'(v.md);
    start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    lat = 1;
    while (!done_irq_p && lat < 3000) begin
      if (v.intf && lat == 3) begin
        start_p = 1'b1; base = 8'd2; exp = 8'd9; m = 8'd13;
      end else begin
        start_p = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_p = 1'b0;
    chk({tag, "_timeout"}, int'(done_irq_p), 1);
    chk({tag, "_result"}, int'(result), v.res);
    chk({tag, "_muls"}, mulcnt - m0, v.muls);
    chk({tag, "_stable"}, stab_err - s0, 0);
    chk({tag, "_busy_done"}, int'(busy), 1);
    if (v.lat >= 0) chk({tag, "_latency"}, lat, v.lat);
    if (v.done_start) begin
      base = 8'd1; exp = 8'd3; m = 8'd5;
      start_p = 1'b1;
    end
    @(posedge clk); #1;
    start_p = 1'b0;
    chk({tag, "_done_single"}, int'(done_irq_p), 0);
    chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_held"}, int'(result), v.res);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{b:3,   e:5,   md:7,   res:5,   muls:3,  lat:-1, intf:0, done_start:0};
    tbl[1] = '{b:6,   e:1,   md:11,  res:6,   muls:0,  lat:10, intf:0, done_start:0};
    tbl[2] = '{b:4,   e:0,   md:2,   res:1,   muls:0,  lat:9,  intf:0, done_start:0};
    tbl[3] = '{b:254, e:255, md:255, res:254, muls:14, lat:-1, intf:0, done_start:0};
    tbl[4] = '{b:3,   e:5,   md:7,   res:5,   muls:3,  lat:-1, intf:1, done_start:1};
    tbl[5] = '{b:10,  e:200, md:13,  res:9,   muls:9,  lat:-1, intf:0, done_start:0};

    #12;
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_irq_p), 0);
    chk("rst_enable", int'(mul_if.mul_enable_p), 0);
    chk("rst_ops", int'(mul_if.mul_a) + int'(mul_if.mul_b) + int'(mul_if.mul_m), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_case(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      vec_t v;
      v.md = int'($urandom_range(2, 255));
      v.b  = int'($urandom_range(0, v.md - 1));
      v.e  = (i < 2) ? 0 : int'($urandom_range(0, 255));
      v.res = ref_pow(v.b, v.e, v.md);
      v.muls = ref_muls(v.e);
      v.lat = (v.e == 0) ? int'(EB) + 1 : -1;
      v.intf = (i % 5 == 1);
      v.done_start = (i % 4 == 2);
      run_case(v, $sformatf("rnd%0d", i));
    end

    // reset while waiting on the final multiply of 3^5 mod 7
    begin
      int m0, guard;
      m0 = mulcnt;
      guard = 0;
      base = 8'd3; exp = 8'd5; m = 8'd7;
      start_p = 1'b1;
      @(posedge clk); #1;
      start_p = 1'b0;
      while (mulcnt - m0 < 3 && guard < 500) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("rst_mid_reach", mulcnt - m0, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_result", int'(result), 0);
      chk("rst_mid_enable", int'(mul_if.mul_enable_p), 0);
      chk("rst_mid_ops", int'(mul_if.mul_a) + int'(mul_if.mul_b) + int'(mul_if.mul_m), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_idle", int'(busy), 0);
      run_case(tbl[0], "after_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
